demux_1xn_stream: RTL
=====================

// Module: demux_1xn_stream
// PURPOSE
// - Parametrised successor to the fixed 1x8 single-bit demux: routes a W-bit
//   valid/ready stream to one of N output channels selected per beat.
// - Adds a broadcast mode, one registered slot per output (1-cycle latency,
//   full throughput) and dropping/counting of out-of-range selects.
// - Sits between a single producer and N independent consumers.
// PARAMETERS
// - W      8  data width in bits per beat
// - N      8  number of output channels (2..256)
// - SEL_W  3  select width = clog2(N), taken from the package function
// - CNT_W  8  width of the saturating drop counter
// PORTS
// - clk        in   1       rising-edge clock
// - rst        in   1       asynchronous reset, active-high
// - in_data    in   W       input beat data
// - in_valid   in   1       input beat present
// - in_sel     in   SEL_W   target channel; sampled with in_valid
// - in_bcast   in   1       1 = copy beat to all N channels; in_sel ignored
// - in_ready   out  1       block accepts the beat this cycle
// - out_data   out  N*W     channel k data at [k*W +: W]
// - out_valid  out  N       per-channel valid
// - out_ready  in   N       per-channel consumer ready
// - drop_cnt   out  CNT_W   count of beats dropped for in_sel >= N
// BEHAVIOUR
// - Reset: out_valid=0, out_data=0, drop_cnt=0. Held slot contents are lost,
//   including during mid-transfer; nothing is replayed after release.
// - Slot k can load when it is free:
//   free[k] = !out_valid[k] | out_ready[k].
// - in_ready is combinational from the registered state, in_sel, in_bcast and
//   out_ready. It never depends on in_valid.
//   - unicast, in_sel<N: free[in_sel]
//   - broadcast: AND of free[0..N-1]
//   - unicast, in_sel>=N: 1 (the beat is dropped)
// - A transfer happens when in_valid & in_ready.
//   - Unicast: slot in_sel loads in_data and sets out_valid on the next edge.
//   - Broadcast: every slot loads.
//   - Latency: 1 cycle from input to output.
// - Output handshake on out_valid[k] & out_ready[k]:
//   - clears slot k unless it reloads on the same edge.
//   - Simultaneous drain and load keeps out_valid[k]=1 with the new data, so
//     one beat per cycle per channel is sustained.
// - A slot holding data while out_ready[k]=0 keeps out_data and out_valid
//   stable (standard no-retract rule).
// - Invalid select: the beat is consumed with no output change.
//   drop_cnt += 1, saturating at 2^CNT_W-1. Broadcast is never counted as a drop.
// - out_data of an invalid slot holds its last value; consumers must ignore it.
// - Power-of-2 N: in_sel>=N is unreachable, and the drop path must still
//   synthesise cleanly.
// - Input-side rule: in_valid must not drop before acceptance; the block does
//   not check this.
// STRUCTURE
// - Package demux_pkg:
//   - function clog2
//   - localparams for default W/N/CNT_W
//   - typedef sel_t
// - Sub-module demux_slot, instantiated N times via generate. Each is a
//   one-entry register with load, data_in, out_valid, out_ready and free.
// - The top level holds the select decode, the in_ready reduction and the
//   drop counter.
// TESTING
// - Reset: assert rst mid-stream with slots 2 and 5 full.
//   -> out_valid=0, drop_cnt=0 asynchronously, before the next clk edge.
// - Unicast: in_sel=5, in_data=0xA5, all out_ready=1.
//   -> next cycle out_valid=8'b0010_0000 and channel 5 = 0xA5.
// - Backpressure: out_ready[3]=0 with slot 3 full; offer in_sel=3.
//   -> in_ready=0 and data is held.
//   -> A beat to in_sel=4 in the same state is accepted.
// - Broadcast: in_bcast=1, in_data=0x3C with slot 1 full and out_ready[1]=0.
//   -> in_ready=0.
//   -> After the release, all 8 channels show 0x3C with out_valid=8'hFF.
// - Invalid select (N=6, SEL_W=3): send in_sel=7 three times.
//   -> in_ready=1, no out_valid change, drop_cnt=3.
//   -> Saturation check with CNT_W=2: after 5 drops, drop_cnt=3.
// - Throughput: 16 back-to-back beats to channel 0 with out_ready[0]=1.
//   -> in_ready stays 1; output data 0..15 appears in order, one per cycle.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types, default sizes and the select-width helper for the 1xN stream demux.
package demux_pkg;

  // Ceiling log2, never less than 1 so a 2-channel demux still gets a select bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_W     = 8;
  localparam int DEF_N     = 8;
  localparam int DEF_CNT_W = 8;

  typedef logic [clog2(DEF_N)-1:0] sel_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel: loads a beat, holds it
// under backpressure, and accepts a new beat on the same edge it drains.
module demux_slot
  import demux_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data_in,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  output logic         free
);

  logic         valid_d, valid_q;
  logic [W-1:0] data_d,  data_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the data register is reset too, because the channel is required to show zero after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign free      = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/demux_1xn_stream.sv
// Routes a W-bit valid/ready stream to one of N registered output channels,
// with broadcast and a saturating count of beats dropped for out-of-range selects.
module demux_1xn_stream
  import demux_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int N     = DEF_N,
  parameter int SEL_W = clog2(N),
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_sel,
  input  logic             in_bcast,
  output logic             in_ready,
  output logic [N*W-1:0]   out_data,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [N-1:0]     slot_free;
  logic [N-1:0]     slot_load;
  logic             sel_ok;
  logic             sel_free;
  logic             fire;
  logic             drop;
  logic [CNT_W-1:0] drop_cnt_d, drop_cnt_q;

  // With a power-of-2 N every select encoding is a real channel, so the range test folds away.
  if ((1 << SEL_W) == N) begin : g_sel_full
    assign sel_ok = 1'b1;
  end else begin : g_sel_partial
    localparam logic [SEL_W:0] N_LIMIT = (SEL_W + 1)'(N);
    assign sel_ok = {1'b0, in_sel} < N_LIMIT;
  end

  always_comb begin
    sel_free = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (in_sel == SEL_W'(k)) sel_free = slot_free[k];
    end

    if (in_bcast)    in_ready = &slot_free;
    else if (sel_ok) in_ready = sel_free;
    else             in_ready = 1'b1;

    fire = in_valid & in_ready;
    drop = fire & ~in_bcast & ~sel_ok;

    for (int k = 0; k < N; k++) begin
      slot_load[k] = fire & (in_bcast | (sel_ok & (in_sel == SEL_W'(k))));
    end

    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;

  for (genvar k = 0; k < N; k++) begin : g_slot
    demux_slot #(.W(W)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (slot_load[k]),
      .data_in   (in_data),
      .out_ready (out_ready[k]),
      .out_data  (out_data[k*W +: W]),
      .out_valid (out_valid[k]),
      .free      (slot_free[k])
    );
  end

endmodule
